// File: rtl/mc_main_controller.sv
// ---------------------------------------------------------------------------
// mc_main_controller
//   Control unit for a multi-cycle RV32I core. A Moore FSM sequences each
//   instruction through fetch, decode, execute, memory and writeback steps.
//   A small ALU decoder turns the FSM's coarse ALU request plus the
//   funct3/funct7b5 fields into the datapath ALU operation.
//   Supported: lw, sw, R-type ALU, I-type ALU, beq/bne, jal.
//
// Ports
//   clk, rst     clock (posedge) and synchronous active-high reset
//   op           IR[6:0] opcode
//   funct3       IR[14:12]
//   funct7b5     IR[30]
//   zero         ALU zero flag for the current cycle
//   pc_write     PC load enable
//   adr_src      memory address select: 0=PC, 1=ALUOut
//   mem_write    data memory write enable
//   ir_write     IR / OldPC load enable
//   reg_write    register file WE3
//   result_src   00=ALUOut, 01=MemData, 10=ALUResult
//   alu_src_a    00=PC, 01=OldPC, 10=RD1
//   alu_src_b    00=RD2, 01=ImmExt, 10=const 4
//   imm_src      00=I, 01=S, 10=B, 11=J
//   alu_control  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//   state_o      current FSM state (debug)
// ---------------------------------------------------------------------------
module mc_main_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Coarse ALU request from the FSM; the decoder below refines FUNC.
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [1:0]         alu_op;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  assign state_o = state;

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = S_FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Compute the branch target early; it waits in ALUOut for BRANCH.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BR:        state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = ALUOP_FUNC;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = ALUOP_FUNC;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        // Only beq/bne are implemented; other funct3 values fall through.
        pc_write  = ((funct3 == 3'b000) &&  zero) ||
                    ((funct3 == 3'b001) && !zero);
      end
      S_JAL: begin
        // Link value PC+4 goes through ALUOut while PC loads the target.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // op[5] separates R-type (sub allowed) from I-type (addi ignores IR[30]).
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALUOP_SUB:  alu_control = 3'b001;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  alu_control = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b100:  alu_control = 3'b100;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default:    alu_control = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_mc_main_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_main_controller
//   Scoreboard bench for mc_main_controller. The stimulus process issues
//   instructions and pushes the expected per-cycle control word, derived
//   from each instruction's step sequence, into a queue. A monitor on the
//   falling edge pops one entry per cycle and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_mc_main_controller;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
  } ctl_t;

  typedef enum int { K_LW, K_SW, K_R, K_I, K_BR, K_JAL, K_NOP } kind_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  mc_main_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .state_o(state_o)
  );

  always #5 clk = ~clk;

  ctl_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  ctl_t act;
  assign act = '{state_o, pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, imm_src, alu_control};

  task automatic check(input string name, input ctl_t got, input ctl_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b a=%b b=%b imm=%b alu=%b | want st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b a=%b b=%b imm=%b alu=%b",
               name, $time, got.state, got.pc_write, got.adr_src, got.mem_write,
               got.ir_write, got.reg_write, got.result_src, got.alu_src_a,
               got.alu_src_b, got.imm_src, got.alu_control, want.state,
               want.pc_write, want.adr_src, want.mem_write, want.ir_write,
               want.reg_write, want.result_src, want.alu_src_a, want.alu_src_b,
               want.imm_src, want.alu_control);
    end
  endtask

  // Monitor: one control word per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow t=%0t: got st=%0d, want an expected entry", $time, state_o);
      end else begin
        check("ctl", act, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic kind_t classify(input logic [6:0] o);
    case (o)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      default:    return K_NOP;
    endcase
  endfunction

  function automatic logic [1:0] imm_for(input kind_t k);
    case (k)
      K_SW:    return 2'b01;
      K_BR:    return 2'b10;
      K_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // ALU operation an arithmetic instruction asks for.
  function automatic logic [2:0] alu_for(input kind_t k, input logic [2:0] f3,
                                         input logic f7);
    case (f3)
      3'd0:    return (k == K_R && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd4:    return 3'b100;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctl_t rec(input int s, input logic [1:0] imm);
    ctl_t r;
    r = '0;
    r.state = 4'(s);
    r.imm_src = imm;
    return r;
  endfunction

  // Issue one instruction; optionally pulse rst during step rst_step,
  // which truncates the instruction after that step.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input int rst_step);
    kind_t      k;
    logic [1:0] im;
    ctl_t       steps[$];
    ctl_t       c;
    k  = classify(o);
    im = imm_for(k);

    c = rec(0, im); c.ir_write = 1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
    c.pc_write = 1; steps.push_back(c);
    c = rec(1, im); c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; steps.push_back(c);

    case (k)
      K_LW, K_SW: begin
        c = rec(2, im); c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; steps.push_back(c);
        if (k == K_LW) begin
          c = rec(3, im); c.adr_src = 1; steps.push_back(c);
          c = rec(4, im); c.result_src = 2'b01; c.reg_write = 1; steps.push_back(c);
        end else begin
          c = rec(5, im); c.adr_src = 1; c.mem_write = 1; steps.push_back(c);
        end
      end
      K_R, K_I: begin
        c = rec(k == K_R ? 6 : 7, im); c.alu_src_a = 2'b10;
        c.alu_src_b = (k == K_R) ? 2'b00 : 2'b01;
        c.alu_control = alu_for(k, f3, f7); steps.push_back(c);
        c = rec(8, im); c.reg_write = 1; steps.push_back(c);
      end
      K_BR: begin
        c = rec(9, im); c.alu_src_a = 2'b10; c.alu_control = 3'b001;
        c.pc_write = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z); steps.push_back(c);
      end
      K_JAL: begin
        c = rec(10, im); c.alu_src_a = 2'b01; c.alu_src_b = 2'b10;
        c.pc_write = 1; steps.push_back(c);
        c = rec(8, im); c.reg_write = 1; steps.push_back(c);
      end
      default: ;
    endcase

    foreach (steps[i]) begin
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      exp_q.push_back(steps[i]);
      mon_en = 1'b1;
      if (i == rst_step) rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      if (i == rst_step) break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] o;
    int         pick;
    int         rs;

    // Two reset edges; the cycle after the first must already show FETCH.
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{state: 4'd0, pc_write: 1, adr_src: 0, mem_write: 0,
                      ir_write: 1, reg_write: 0, result_src: 2'b10,
                      alu_src_a: 2'b00, alu_src_b: 2'b10, imm_src: 2'b00,
                      alu_control: 3'b000});
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases.
    issue(7'b0000011, 3'd2, 1'b0, 1'b0, -1);  // lw
    issue(7'b0110011, 3'd0, 1'b1, 1'b0, -1);  // sub
    issue(7'b0010011, 3'd0, 1'b1, 1'b0, -1);  // addi, IR[30] set
    issue(7'b0110011, 3'd7, 1'b0, 1'b0, -1);  // and
    issue(7'b1100011, 3'd0, 1'b0, 1'b1, -1);  // beq taken
    issue(7'b1100011, 3'd0, 1'b0, 1'b0, -1);  // beq not taken
    issue(7'b1100011, 3'd1, 1'b0, 1'b1, -1);  // bne not taken
    issue(7'b1100011, 3'd1, 1'b0, 1'b0, -1);  // bne taken
    issue(7'b1100011, 3'd4, 1'b0, 1'b1, -1);  // unsupported branch
    issue(7'b1101111, 3'd0, 1'b0, 1'b0, -1);  // jal
    issue(7'b0100011, 3'd2, 1'b0, 1'b0, 2);   // sw, reset in MEMADR
    issue(7'b0100011, 3'd2, 1'b0, 1'b0, -1);  // sw complete
    issue(7'b1111111, 3'd0, 1'b0, 1'b0, -1);  // unknown op

    // Randomized mix, with occasional mid-instruction reset.
    for (int n = 0; n < 300; n++) begin
      pick = int'($urandom_range(0, 6));
      case (pick)
        0: o = 7'b0000011;
        1: o = 7'b0100011;
        2: o = 7'b0110011;
        3: o = 7'b0010011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        default: o = 7'($urandom);
      endcase
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      issue(o, 3'($urandom), 1'($urandom), 1'($urandom), rs);
    end

    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
